lake_cfg_loader: RTL

Receives the static configuration of a `lakespec` instance as 32-bit addressed word writes over a narrow config bus. Assembles the words into the wide `config_memory` vector that drives the accelerator. Provides one-cycle word readback and tracks load completeness. Sits between the global configuration controller and `lakespec.config_memory`, replacing direct wide-vector loading.

---
 rtl/lake_cfg_pkg.sv | 20 ++
 rtl/lake_cfg_readback.sv | 58 +++++
 rtl/lake_cfg_loader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/lake_cfg_pkg.sv
// lake_cfg_pkg: shared definitions for the lakespec configuration loader.
//   CFG_WORD_W      - width of one config bus word (fixed at 32).
//   cfg_state_t     - load progress: IDLE (nothing written), LOAD (partial),
//                     READY (every word written).
//   cfg_num_words() - number of bus words needed to cover a vector width.
package lake_cfg_pkg;

  localparam int CFG_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } cfg_state_t;

  function automatic int cfg_num_words(input int size);
    return (size + CFG_WORD_W - 1) / CFG_WORD_W;
  endfunction

endpackage

// File: rtl/lake_cfg_readback.sv
// lake_cfg_readback: one-cycle word readback for the config loader.
// Selects the addressed word from the stored vector, zeroes the bits of the
// last word that lie beyond CONFIG_MEMORY_SIZE, and registers the result.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   rd          - read strobe
//   addr        - word address (out of range reads return zero)
//   words       - stored contents, NUM_WORDS words packed LSB first
//   rd_data     - registered read data
//   rd_valid    - one-cycle pulse, the cycle after rd
module lake_cfg_readback
  import lake_cfg_pkg::*;
#(
  parameter int CONFIG_MEMORY_SIZE = 512,
  parameter int NUM_WORDS          = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             rd,
  input  logic [31:0]                      addr,
  input  logic [NUM_WORDS*CFG_WORD_W-1:0]  words,
  output logic [CFG_WORD_W-1:0]            rd_data,
  output logic                             rd_valid
);

  localparam int AW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int LAST_BITS = CONFIG_MEMORY_SIZE - (NUM_WORDS - 1) * CFG_WORD_W;
  localparam logic [CFG_WORD_W-1:0] LAST_MASK =
    {CFG_WORD_W{1'b1}} >> (CFG_WORD_W - LAST_BITS);

  logic                  in_range;
  logic [AW-1:0]         widx;
  logic [CFG_WORD_W-1:0] sel;

  assign in_range = (addr < 32'(NUM_WORDS));
  assign widx     = addr[AW-1:0];

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (widx == AW'(i)) sel = words[i*CFG_WORD_W +: CFG_WORD_W];
    end
    // Storage of the last word may hold bits past the vector end; hide them.
    if (widx == AW'(NUM_WORDS - 1)) sel = sel & LAST_MASK;
    if (!in_range) sel = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd;
      if (rd) rd_data <= sel;
    end
  end

endmodule

// File: rtl/lake_cfg_loader.sv
// lake_cfg_loader: assembles 32-bit addressed config writes into the wide
// lakespec config_memory vector, with word readback and load tracking.
// Optional feature macro: LAKE_CFG_SHADOW_EN -- writes go to a shadow copy
// that is transferred to config_memory when flush falls.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   flush            - accelerator flush; high permits rewrites once READY
//   config_addr      - word address (word i = bits [32i+31:32i])
//   config_data      - write data
//   config_write     - write strobe
//   config_read      - read strobe
//   config_rd_data   - readback data, valid with config_rd_valid
//   config_rd_valid  - one-cycle pulse the cycle after config_read
//   config_memory    - assembled configuration vector
//   config_valid     - every word written since reset (and transferred)
//   config_err       - sticky error: bad address or write while locked
//   dbg_state        - current load state (cfg_state_t encoding)
// Bus handshake: no ready/backpressure; a strobe is consumed on the rising
// edge it is seen, one read and one write (same address) per cycle.
module lake_cfg_loader
  import lake_cfg_pkg::*;
#(
  parameter int CONFIG_MEMORY_SIZE = 512
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [31:0]                   config_addr,
  input  logic [31:0]                   config_data,
  input  logic                          config_write,
  input  logic                          config_read,
  output logic [31:0]                   config_rd_data,
  output logic                          config_rd_valid,
  output logic [CONFIG_MEMORY_SIZE-1:0] config_memory,
  output logic                          config_valid,
  output logic                          config_err,
  output logic [1:0]                    dbg_state
);

  localparam int NUM_WORDS = cfg_num_words(CONFIG_MEMORY_SIZE);
  localparam int PAD_W     = NUM_WORDS * CFG_WORD_W;
  localparam int AW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  cfg_state_t           state_q, state_d;
  logic [NUM_WORDS-1:0] mask_q, mask_d;
  logic [PAD_W-1:0]     store_q;
  logic                 err_q;
  logic                 addr_ok, ready, wr_acc, wr_bad, rd_bad;
  logic [AW-1:0]        widx;

  assign addr_ok = (config_addr < 32'(NUM_WORDS));
  assign widx    = config_addr[AW-1:0];
  assign ready   = (state_q == READY);
  // Once READY the configuration is locked unless flush opens the window.
  assign wr_acc  = config_write && addr_ok && (!ready || flush);
  assign wr_bad  = config_write && (!addr_ok || (ready && !flush));
  assign rd_bad  = config_read && !addr_ok;

  always_comb begin
    mask_d = mask_q;
    if (wr_acc) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (widx == AW'(i)) mask_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wr_acc) state_d = (&mask_d) ? READY : LOAD;
      LOAD:    if (&mask_d) state_d = READY;
      READY:   state_d = READY;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      err_q   <= err_q | wr_bad | rd_bad;
    end
  end

  // Word storage; bits of the last word past the vector end are never
  // exported and are masked on readback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q <= '0;
    end else begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (wr_acc && (widx == AW'(i)))
          store_q[i*CFG_WORD_W +: CFG_WORD_W] <= config_data;
      end
    end
  end

`ifdef LAKE_CFG_SHADOW_EN
  logic                          flush_q;
  logic                          xfer;
  logic                          xfer_seen_q;
  logic [CONFIG_MEMORY_SIZE-1:0] cfg_mem_q;

  // Transfer on the first edge with flush low after an edge with it high.
  assign xfer = flush_q && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q     <= 1'b0;
      xfer_seen_q <= 1'b0;
      cfg_mem_q   <= '0;
    end else begin
      flush_q <= flush;
      if (xfer) cfg_mem_q <= store_q[CONFIG_MEMORY_SIZE-1:0];
      if (xfer && ready) xfer_seen_q <= 1'b1;
    end
  end

  assign config_memory = cfg_mem_q;
  assign config_valid  = ready && xfer_seen_q;
`else
  assign config_memory = store_q[CONFIG_MEMORY_SIZE-1:0];
  assign config_valid  = ready;
`endif

  assign config_err = err_q;
  assign dbg_state  = state_q;

  lake_cfg_readback #(
    .CONFIG_MEMORY_SIZE (CONFIG_MEMORY_SIZE),
    .NUM_WORDS          (NUM_WORDS)
  ) u_readback (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd       (config_read),
    .addr     (config_addr),
    .words    (store_q),
    .rd_data  (config_rd_data),
    .rd_valid (config_rd_valid)
  );

endmodule
